// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit for the EX stage of the pipelined MIPS core.
// Owns the architectural HI/LO registers. It executes mult/multu with one
// radix-2 shift-add step per cycle and div/divu with one restoring-division
// step per cycle, then a FIX cycle for the sign correction and writeback.
// mthi/mtlo write HI/LO directly at the accepting edge.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request the operation selected by Funct (only honoured in IDLE)
//   Funct    R-type function field: 18 mult, 19 multu, 1A div, 1B divu,
//            11 mthi, 13 mtlo (hex)
//   a        rs operand (multiplicand / dividend / mthi-mtlo source)
//   b        rt operand (multiplier / divisor)
//   flush    abort the in-flight operation, or suppress a same-cycle start
//   busy     high while a mult/div is in progress (WIDTH+1 cycles)
//   done     one-cycle pulse when HI/LO are written by mult/div
//   hi, lo   HI and LO registers
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}.
    // DIV: low half holds dividend bits shifting out / quotient bits shifting in.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;     // remainder, always < divisor
    logic               q_neg_q, q_neg_d; // product/quotient must be negated
    logic               r_neg_q, r_neg_d; // remainder must be negated
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        is_div_d  = is_div_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        signed_op = (Funct == F_MULT) || (Funct == F_DIV);
        abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_fix  = q_neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    case (Funct)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            state_d  = (Funct == F_DIV || Funct == F_DIVU) ? DIV : MUL;
                            is_div_d = (Funct == F_DIV || Funct == F_DIVU);
                            div0_d   = (b == '0);
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opnd_d   = abs_b;
                            rem_d    = '0;
                            q_neg_d  = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_d  = signed_op && a[WIDTH-1];
                            cnt_d    = CNT_W'(WIDTH - 1);
                        end
                        F_MTHI:  hi_d = a;
                        F_MTLO:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIV: begin
                rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // With a zero divisor every trial subtract succeeds, so the
                    // remainder ends up as |a|; re-applying a's sign restores a.
                    lo_d = div0_q ? {WIDTH{1'b1}}
                                  : (q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    hi_d = r_neg_q ? -rem_q : rem_q;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase

        // flush wins over everything: no accept, no step, no writeback.
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            rem_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
